shift_unit_mc: RTL

Multi-cycle, parametrised shift unit for the RISC-V execute stage. It replaces the single-cycle combinational shifter where shifter area or timing matters. It accepts one operation at a time over a valid/ready handshake and shifts by up to STEP bit positions per clock. It adds rotate-right and a held, back-pressured result to the existing SRL/SLL/SRA set.

---
 rtl/shift_unit_mc_pkg.sv | 24 ++
 rtl/shift_unit_mc_if.sv | 29 ++
 rtl/shift_unit_mc_step.sv | 43 ++++
 rtl/shift_unit_mc.sv | 87 ++++++++
 4 files changed

// File: rtl/shift_unit_mc_pkg.sv
// Shared definitions for the multi-cycle shift unit: op encodings, FSM states
// and the shift-amount width helper.
package shift_pkg;

  localparam logic [1:0] SH_SRL = 2'b00;
  localparam logic [1:0] SH_SLL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Shift-amount width: log2 of the (power-of-two) operand width.
  function automatic int calc_shw(input int xlen);
    int w;
    w = 0;
    while ((1 << w) < xlen) w++;
    return w;
  endfunction

endpackage

// File: rtl/shift_unit_mc_if.sv
// Request/result bundle of the shift unit; slave is the unit, master the issuer.
interface shift_unit_mc_if #(
  parameter int XLEN = 32
) ();
  import shift_pkg::*;

  localparam int SHW = calc_shw(XLEN);

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a;
  logic [SHW-1:0]  shamt;
  logic [1:0]      op;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] r;
  logic            busy;

  modport master (
    output in_valid, a, shamt, op, out_ready,
    input  in_ready, out_valid, r, busy
  );

  modport slave (
    input  in_valid, a, shamt, op, out_ready,
    output in_ready, out_valid, r, busy
  );

endinterface

// File: rtl/shift_unit_mc_step.sv
// Combinational single-step shifter: moves the word by 0..STEP positions
// according to op. Only a STEP-wide amount is decoded to keep the mux small.
module shift_step
  import shift_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic [XLEN-1:0]             word,
  input  logic [$clog2(STEP+1)-1:0]   amount,
  input  logic [1:0]                  op,
  output logic [XLEN-1:0]             result
);

  localparam int LW = $clog2(XLEN) + 1;

  logic signed [XLEN-1:0] word_s;
  logic [XLEN-1:0]        srl_res;
  logic [XLEN-1:0]        sll_res;
  logic [XLEN-1:0]        sra_res;
  logic [XLEN-1:0]        ror_res;
  logic [LW-1:0]          wrap_amt;

  assign word_s   = word;
  // amount == 0 gives wrap_amt == XLEN, which shifts the wrapped part fully out.
  assign wrap_amt = LW'(XLEN) - LW'(amount);
  assign srl_res  = word >> amount;
  assign sll_res  = word << amount;
  assign sra_res  = $unsigned(word_s >>> amount);
  assign ror_res  = (word >> amount) | (word << wrap_amt);

  always_comb begin
    result = srl_res;
    case (op)
      SH_SRL:  result = srl_res;
      SH_SLL:  result = sll_res;
      SH_SRA:  result = sra_res;
      SH_ROR:  result = ror_res;
      default: result = srl_res;
    endcase
  end

endmodule

// File: rtl/shift_unit_mc.sv
// Multi-cycle shift unit: accepts one request, shifts up to STEP bits per clock,
// then holds the result until the consumer takes it.
module shift_unit_mc
  import shift_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  shift_unit_mc_if.slave   bus
);

  localparam int SHW = calc_shw(XLEN);
  localparam int AW  = $clog2(STEP + 1);
  localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);

  state_e          state_q, state_d;
  logic [XLEN-1:0] work_q, work_d;
  logic [SHW-1:0]  rem_q, rem_d;
  logic [1:0]      op_q, op_d;
  logic [AW-1:0]   step_amt;
  logic [XLEN-1:0] step_out;

  // Step size is min(STEP, rem); rem never exceeds XLEN-1 so it fits in SHW bits.
  always_comb begin
    if ({1'b0, rem_q} >= STEP_W) step_amt = AW'(STEP);
    else                         step_amt = AW'(rem_q);
  end

  shift_step #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) u_step (
    .word   (work_q),
    .amount (step_amt),
    .op     (op_q),
    .result (step_out)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d  = bus.a;
          rem_d   = bus.shamt;
          op_d    = bus.op;
          state_d = (bus.shamt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        work_d = step_out;
        rem_d  = rem_q - SHW'(step_amt);
        if (rem_d == '0) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      op_q    <= SH_SRL;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
    end
  end

  // The working register doubles as the result register; outputs come only from flops.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.r         = work_q;

endmodule
